kronecker_sequencer: RTL and testbench
======================================

KRONECKER_SEQUENCER -- requirements
Module: kronecker_sequencer

Interface
REQ-001 The block SHALL have parameter word_size, default 32, element width in bits.
REQ-002 The block SHALL have parameter Amatrixrownum, default 2, rows of A; Amatrixcolnum, default 2, columns of A.
REQ-003 The block SHALL have parameter Bmatrixrownum, default 2, rows of B; Bmatrixcolnum, default 2, columns of B.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: start  input  1  request to begin one product; accepted only in IDLE.
REQ-008 Port: A  input  Amatrixrownum*Amatrixcolnum*word_size  matrix A, row-major; element [0][0] in the most significant word.
REQ-009 Port: B  input  Bmatrixrownum*Bmatrixcolnum*word_size  matrix B, same packing as A.
REQ-010 Port: busy  output  1  high from the cycle after start acceptance through the DONE cycle exclusive.
REQ-011 Port: out_valid  output  1  out_data holds a valid product element.
REQ-012 Port: out_ready  input  1  consumer accepts the element when out_valid and out_ready are both high.
REQ-013 Port: out_data  output  word_size  current element of TP = A kron B.
REQ-014 Port: out_row  output  clog2(Amatrixrownum*Bmatrixrownum) (min 1)  TP row index of out_data.
REQ-015 Port: out_col  output  clog2(Amatrixcolnum*Bmatrixcolnum) (min 1)  TP column index of out_data.
REQ-016 Port: out_last  output  1  high with the final element (last row, last column).
REQ-017 Port: done  output  1  one-cycle pulse after the final element is accepted.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start in IDLE; RUN->DONE on acceptance of the out_last element; DONE->IDLE unconditionally after one cycle.
REQ-019 On start acceptance, A and B SHALL be registered internally; later changes on A/B SHALL NOT affect the running product.
REQ-020 start while busy or in DONE SHALL be ignored.
REQ-021 The first element (row 0, col 0) SHALL appear with out_valid=1 in the cycle after start acceptance (latency 1).
REQ-022 Elements SHALL be emitted in TP row-major order, one per accepted handshake, Amatrixrownum*Bmatrixrownum*Amatrixcolnum*Bmatrixcolnum elements total.
REQ-023 Element (r,c) SHALL equal A[r / Bmatrixrownum][c / Bmatrixcolnum] * B[r % Bmatrixrownum][c % Bmatrixcolnum], realised with nested wrap-around counters (B col, A col, B row, A row), not dividers.
REQ-024 The product SHALL be truncated to its low word_size bits, unsigned.
REQ-025 A single shared multiplier SHALL be used; out_data, out_row, out_col, out_last SHALL be registered.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_row, out_col, out_last SHALL hold stable.
REQ-027 On acceptance of a non-last element the next element SHALL be presented in the following cycle (full throughput with out_ready held high).
REQ-028 On acceptance of the last element out_valid SHALL drop in the following cycle, coinciding with done=1.
REQ-029 out_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, counters 0, busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, done=0, including mid-RUN; no element or done is produced for an aborted run.
REQ-031 After rst_n deasserts, the first start SHALL behave per REQ-021.

Verification
REQ-032 Defaults, A=[1 2;3 4], B=[5 6;7 8], out_ready=1, pulse start -> 16 consecutive elements 5,6,10,12,7,8,14,16,15,18,20,24,21,24,28,32 from cycle after start; out_last on 32; done next cycle.
REQ-033 Same stimulus, out_ready low for 3 cycles at element (1,2) -> out_data=14, out_row=1, out_col=2 held 3 cycles; sequence otherwise unchanged.
REQ-034 word_size=8, A00=16, B00=16 -> element (0,0) = 0x00 (truncation).
REQ-035 start pulsed again at element 5 with different A/B -> ignored; output identical to REQ-032.
REQ-036 rst_n asserted at element 9 -> all outputs 0 same cycle; new start after release restarts at element (0,0)=5.

Source files
------------

// File: rtl/kronecker_sequencer.sv
// ============================================================================
// Module      : kronecker_sequencer
// Description : Streams the Kronecker product A (x) B element by element in
//               row-major order through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kronecker_sequencer #(
    parameter int word_size     = 32,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2,
    localparam int c_ROW_W = (Amatrixrownum * Bmatrixrownum > 1) ?
                             $clog2(Amatrixrownum * Bmatrixrownum) : 1,
    localparam int c_COL_W = (Amatrixcolnum * Bmatrixcolnum > 1) ?
                             $clog2(Amatrixcolnum * Bmatrixcolnum) : 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] A,
    input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] B,
    output logic                                           busy,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [word_size-1:0]                           out_data,
    output logic [c_ROW_W-1:0]                             out_row,
    output logic [c_COL_W-1:0]                             out_col,
    output logic                                           out_last,
    output logic                                           done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam int c_A_LEN = Amatrixrownum * Amatrixcolnum * word_size;
    localparam int c_B_LEN = Bmatrixrownum * Bmatrixcolnum * word_size;
    localparam int c_AR_W  = (Amatrixrownum > 1) ? $clog2(Amatrixrownum) : 1;
    localparam int c_AC_W  = (Amatrixcolnum > 1) ? $clog2(Amatrixcolnum) : 1;
    localparam int c_BR_W  = (Bmatrixrownum > 1) ? $clog2(Bmatrixrownum) : 1;
    localparam int c_BC_W  = (Bmatrixcolnum > 1) ? $clog2(Bmatrixcolnum) : 1;
    localparam int c_TR    = Amatrixrownum * Bmatrixrownum;
    localparam int c_TC    = Amatrixcolnum * Bmatrixcolnum;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_A_LEN-1:0]   r_a;
    logic [c_B_LEN-1:0]   r_b;
    logic [c_A_LEN-1:0]   w_a_src;
    logic [c_B_LEN-1:0]   w_b_src;
    logic [word_size-1:0] w_a_elem [Amatrixrownum][Amatrixcolnum];
    logic [word_size-1:0] w_b_elem [Bmatrixrownum][Bmatrixcolnum];
    logic [word_size-1:0] w_mul_a;
    logic [word_size-1:0] w_mul_b;
    logic [word_size-1:0] w_prod;

    // Counters address the element that will be loaded next.
    logic [c_AR_W-1:0]    r_ar;
    logic [c_AC_W-1:0]    r_ac;
    logic [c_BR_W-1:0]    r_br;
    logic [c_BC_W-1:0]    r_bc;
    logic [c_ROW_W-1:0]   r_nrow;
    logic [c_COL_W-1:0]   r_ncol;

    logic w_bc_wrap, w_ac_wrap, w_br_wrap, w_ar_wrap, w_final;
    logic w_col_wrap, w_row_wrap;
    logic w_accept, w_load, w_fin_accept;

    // While idle the counters sit at zero, so the live inputs feed element (0,0).
    assign w_a_src = (r_state == c_IDLE) ? A : r_a;
    assign w_b_src = (r_state == c_IDLE) ? B : r_b;

    for (genvar i = 0; i < Amatrixrownum; i++) begin : g_a_row
        for (genvar j = 0; j < Amatrixcolnum; j++) begin : g_a_col
            assign w_a_elem[i][j] =
                w_a_src[(Amatrixrownum*Amatrixcolnum-1-(i*Amatrixcolnum+j))*word_size +: word_size];
        end
    end

    for (genvar i = 0; i < Bmatrixrownum; i++) begin : g_b_row
        for (genvar j = 0; j < Bmatrixcolnum; j++) begin : g_b_col
            assign w_b_elem[i][j] =
                w_b_src[(Bmatrixrownum*Bmatrixcolnum-1-(i*Bmatrixcolnum+j))*word_size +: word_size];
        end
    end

    assign w_mul_a = w_a_elem[r_ar][r_ac];
    assign w_mul_b = w_b_elem[r_br][r_bc];
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_bc_wrap  = (r_bc == c_BC_W'(Bmatrixcolnum - 1));
    assign w_ac_wrap  = (r_ac == c_AC_W'(Amatrixcolnum - 1));
    assign w_br_wrap  = (r_br == c_BR_W'(Bmatrixrownum - 1));
    assign w_ar_wrap  = (r_ar == c_AR_W'(Amatrixrownum - 1));
    assign w_final    = w_bc_wrap & w_ac_wrap & w_br_wrap & w_ar_wrap;
    assign w_col_wrap = (r_ncol == c_COL_W'(c_TC - 1));
    assign w_row_wrap = (r_nrow == c_ROW_W'(c_TR - 1));

    assign w_accept     = (r_state == c_RUN) & out_valid & out_ready;
    assign w_load       = ((r_state == c_IDLE) & start) | (w_accept & ~out_last);
    assign w_fin_accept = w_accept & out_last;

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_RUN;
            c_RUN:   if (w_fin_accept) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_ar      <= '0;
            r_ac      <= '0;
            r_br      <= '0;
            r_bc      <= '0;
            r_nrow    <= '0;
            r_ncol    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && start) begin
                r_a <= A;
                r_b <= B;
            end
            if (w_load) begin
                out_valid <= 1'b1;
                out_data  <= w_prod;
                out_row   <= r_nrow;
                out_col   <= r_ncol;
                out_last  <= w_final;
                // Advancing past the final element wraps everything back to zero.
                r_bc   <= w_bc_wrap ? '0 : r_bc + 1'b1;
                r_ncol <= w_col_wrap ? '0 : r_ncol + 1'b1;
                if (w_bc_wrap) begin
                    r_ac <= w_ac_wrap ? '0 : r_ac + 1'b1;
                end
                if (w_bc_wrap && w_ac_wrap) begin
                    r_br <= w_br_wrap ? '0 : r_br + 1'b1;
                end
                if (w_bc_wrap && w_ac_wrap && w_br_wrap) begin
                    r_ar <= w_ar_wrap ? '0 : r_ar + 1'b1;
                end
                if (w_col_wrap) begin
                    r_nrow <= w_row_wrap ? '0 : r_nrow + 1'b1;
                end
            end else if (w_fin_accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kronecker_sequencer.sv
// ============================================================================
// Module      : tb_kronecker_sequencer
// Description : Self-checking bench for kronecker_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kronecker_sequencer;

    localparam int W  = 32;
    localparam int AR = 2;
    localparam int AC = 2;
    localparam int BR = 2;
    localparam int BC = 2;
    localparam int TC = AC * BC;
    localparam int N  = AR * BR * AC * BC;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic [AR*AC*W-1:0] A = '0;
    logic [BR*BC*W-1:0] B = '0;
    logic              busy, out_valid, out_last, done;
    logic [W-1:0]      out_data;
    logic [1:0]        out_row, out_col;

    logic              start2 = 1'b0;
    logic [31:0]       a2 = {8'd16, 8'd3, 8'd5, 8'd255};
    logic [31:0]       b2 = {8'd16, 8'd2, 8'd17, 8'd9};
    logic              busy2, valid2, last2, done2;
    logic              ready2 = 1'b1;
    logic [7:0]        data2;
    logic [1:0]        row2, col2;

    kronecker_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .done(done)
    );

    kronecker_sequencer #(.word_size(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .out_valid(valid2), .out_ready(ready2),
        .out_data(data2), .out_row(row2), .out_col(col2),
        .out_last(last2), .done(done2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: captured matrices, progress index and phase (0 idle, 1 run, 2 done).
    longint unsigned m_a [AR][AC];
    longint unsigned m_b [BR][BC];
    int m_mode = 0;
    int m_idx  = 0;

    function automatic logic [W-1:0] exp_data(input int idx);
        int r, c;
        longint unsigned p;
        r = idx / TC;
        c = idx % TC;
        p = m_a[r / BR][c / BC] * m_b[r % BR][c % BC];
        return p[W-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_idx  = 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    for (int i = 0; i < AR; i++)
                        for (int j = 0; j < AC; j++)
                            m_a[i][j] = A[(AR*AC-1-(i*AC+j))*W +: W];
                    for (int i = 0; i < BR; i++)
                        for (int j = 0; j < BC; j++)
                            m_b[i][j] = B[(BR*BC-1-(i*BC+j))*W +: W];
                    m_idx  = 0;
                    m_mode = 1;
                end
                1: if (out_ready) begin
                    if (m_idx == N - 1) m_mode = 2;
                    else m_idx++;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", out_valid, m_mode == 1);
            check("busy", busy, m_mode == 1);
            check("done", done, m_mode == 2);
            if (m_mode == 1) begin
                check("data", out_data, exp_data(m_idx));
                check("row", out_row, m_idx / TC);
                check("col", out_col, m_idx % TC);
                check("last", out_last, m_idx == N - 1);
            end
        end
    end

    logic [W-1:0] q[$];
    logic [7:0]   q2[$];
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) q.push_back(out_data);
        if (rst_n && valid2 && ready2) q2.push_back(data2);
    end

    logic [W-1:0] golden [16] = '{5, 6, 10, 12, 7, 8, 14, 16, 15, 18, 20, 24, 21, 24, 28, 32};

    task automatic check_seq(input string name);
        check({name, "_len"}, q.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < q.size()) check($sformatf("%s[%0d]", name, i), q[i], golden[i]);
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_valid"}, out_valid, 0);
        check({name, "_data"}, out_data, 0);
        check({name, "_row"}, out_row, 0);
        check({name, "_col"}, out_col, 0);
        check({name, "_last"}, out_last, 0);
        check({name, "_done"}, done, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check({name, "_done_seen"}, done, 1);
        check({name, "_valid_at_done"}, out_valid, 0);
    endtask

    task automatic wait_idx(input int idx, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(m_mode == 1 && m_idx == idx) && n < 200);
        check({name, "_reached"}, (m_mode == 1 && m_idx == idx), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        A = {32'd1, 32'd2, 32'd3, 32'd4};
        B = {32'd5, 32'd6, 32'd7, 32'd8};
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        // Basic full-throughput run, latency one cycle.
        out_ready = 1'b1;
        q.delete();
        pulse_start();
        @(negedge clk);
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 5);
        wait_done("basic");
        check_seq("basic");

        // Backpressure at element (1,2).
        q.delete();
        pulse_start();
        wait_idx(6, "stall");
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("stall_data", out_data, 14);
            check("stall_row", out_row, 1);
            check("stall_col", out_col, 2);
        end
        out_ready = 1'b1;
        wait_done("stall");
        check_seq("stall");

        // Second start mid-run with different matrices is ignored.
        q.delete();
        pulse_start();
        wait_idx(5, "restart");
        A = {32'd9, 32'd9, 32'd9, 32'd9};
        B = {32'd3, 32'd3, 32'd3, 32'd3};
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done("restart");
        check_seq("restart");
        A = {32'd1, 32'd2, 32'd3, 32'd4};
        B = {32'd5, 32'd6, 32'd7, 32'd8};

        // Asynchronous reset mid-run.
        q.delete();
        pulse_start();
        wait_idx(9, "abort");
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check("abort_accepted", q.size(), 9);
        q.delete();
        pulse_start();
        @(negedge clk);
        check("rerun_data", out_data, 5);
        check("rerun_row", out_row, 0);
        check("rerun_col", out_col, 0);
        wait_done("rerun");
        check_seq("rerun");

        // 8-bit instance: truncation of the product.
        q2.delete();
        @(posedge clk); #2 start2 = 1'b1;
        @(posedge clk); #2 start2 = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done2 && n < 200);
        end
        check("w8_done", done2, 1);
        check("w8_len", q2.size(), 16);
        if (q2.size() == 16) begin
            check("w8_e00", q2[0], 8'h00);
            check("w8_e01", q2[1], 8'd32);
            check("w8_e10", q2[4], 8'd16);
            check("w8_e33", q2[15], 8'd247);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
